// File: rtl/rsa_pkg.sv
// Shared constants and types for the RSA sequencer.
//   M, N, Y          : job geometry (X rows, inner dimension, Y columns)
//   IN_LEN, OUT_LEN  : operand / result word widths
//   AW               : operand and result RAM address width
//   TO_CYC           : drain watchdog limit (only used with RSA_SEQ_TIMEOUT_EN)
//   X_LEN/Y_LEN/R_LEN: stream lengths derived from the geometry
package rsa_pkg;

  localparam int unsigned M       = 9;
  localparam int unsigned N       = 3;
  localparam int unsigned Y       = 3;
  localparam int unsigned IN_LEN  = 4;
  localparam int unsigned OUT_LEN = 8;
  localparam int unsigned AW      = 8;
  localparam int unsigned TO_CYC  = 256;

  localparam int unsigned X_LEN = M * N;
  localparam int unsigned Y_LEN = Y * N;
  localparam int unsigned R_LEN = M * Y;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = 32'(i) + 32'd1;
    end
    return r;
  endfunction

  // Offset counters must hold the largest stream length.
  localparam int unsigned CNT_W = clog2(((X_LEN > R_LEN) ? X_LEN : R_LEN) + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rsa_addr_gen.sv
// Address generator: latches a base address on start and produces base + k,
// where k advances by one on each adv. Addresses wrap modulo 2^AW.
//   clk, sys_rst : clock, synchronous active-high reset
//   start        : latch base and clear the offset
//   adv          : advance the offset by one
//   base         : base address to latch
//   addr         : current address (base + offset)
//   last         : offset equals LEN-1 (final element of the stream)
module rsa_addr_gen
  import rsa_pkg::*;
#(
  parameter int unsigned LEN = 1
) (
  input  logic          clk,
  input  logic          sys_rst,
  input  logic          start,
  input  logic          adv,
  input  logic [AW-1:0] base,
  output logic [AW-1:0] addr,
  output logic          last
);

  logic [AW-1:0]    base_q;
  logic [CNT_W-1:0] off_q;

  // Base latch and offset counter.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      base_q <= '0;
      off_q  <= '0;
    end else if (start) begin
      base_q <= base;
      off_q  <= '0;
    end else if (adv) begin
      off_q  <= off_q + CNT_W'(1);
    end
  end

  // Adding in AW bits gives the modulo-2^AW wrap for free.
  assign addr = base_q + AW'(off_q);
  assign last = (off_q == CNT_W'(LEN - 1));

endmodule

// File: rtl/rsa_seq_ctrl.sv
// Sequencer for the RSA systolic array: accepts a job, streams X (M*N words)
// and Y (Y*N words) from the operand RAMs into the array, then collects M*Y
// results into the result RAM.
// Optional feature macro: RSA_SEQ_TIMEOUT_EN adds a DRAIN watchdog that
// raises err and returns to IDLE (no done) after TO_CYC cycles in DRAIN.
// Ports:
//   clk, sys_rst                  : clock, synchronous active-high reset
//   cmd_val/cmd_rdy, cmd_*base    : job command handshake and RAM bases
//   x_rd_*, y_rd_*                : operand RAM reads (1-cycle latency)
//   Xin_*, Yin_*                  : operand streams to the array
//   out_val, out_data             : results from the array
//   res_wr_*                      : result RAM writes (same cycle as out_val)
//   busy, done, err               : status (busy in LOAD/DRAIN, done pulse, sticky err)
module rsa_seq_ctrl
  import rsa_pkg::*;
(
  input  logic               clk,
  input  logic               sys_rst,
  input  logic               cmd_val,
  output logic               cmd_rdy,
  input  logic [AW-1:0]      cmd_xbase,
  input  logic [AW-1:0]      cmd_ybase,
  input  logic [AW-1:0]      cmd_obase,
  output logic               x_rd_en,
  output logic [AW-1:0]      x_rd_addr,
  input  logic [IN_LEN-1:0]  x_rd_data,
  output logic               y_rd_en,
  output logic [AW-1:0]      y_rd_addr,
  input  logic [IN_LEN-1:0]  y_rd_data,
  output logic               Xin_val,
  output logic [IN_LEN-1:0]  Xin_data,
  output logic               Yin_val,
  output logic [IN_LEN-1:0]  Yin_data,
  input  logic               out_val,
  input  logic [OUT_LEN-1:0] out_data,
  output logic               res_wr_en,
  output logic [AW-1:0]      res_wr_addr,
  output logic [OUT_LEN-1:0] res_wr_data,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_t state;
  logic   start;
  logic   x_last;
  logic   y_last;
  logic   r_last;
  logic   res_all;
  logic   wd_hit;

  // cmd_rdy is high exactly in IDLE, so this is the accept condition.
  assign start = (state == IDLE) && cmd_val;

  // Results pass straight through to the RAM while a job is active.
  assign res_wr_en   = out_val && busy;
  assign res_wr_data = res_wr_en ? out_data : '0;

  // RAM data flows through unregistered, aligned with the delayed valids.
  assign Xin_data = Xin_val ? x_rd_data : '0;
  assign Yin_data = Yin_val ? y_rd_data : '0;

  rsa_addr_gen #(.LEN(X_LEN)) u_x_gen (
    .clk     (clk),
    .sys_rst (sys_rst),
    .start   (start),
    .adv     (x_rd_en),
    .base    (cmd_xbase),
    .addr    (x_rd_addr),
    .last    (x_last)
  );

  rsa_addr_gen #(.LEN(Y_LEN)) u_y_gen (
    .clk     (clk),
    .sys_rst (sys_rst),
    .start   (start),
    .adv     (y_rd_en),
    .base    (cmd_ybase),
    .addr    (y_rd_addr),
    .last    (y_last)
  );

  rsa_addr_gen #(.LEN(R_LEN)) u_r_gen (
    .clk     (clk),
    .sys_rst (sys_rst),
    .start   (start),
    .adv     (res_wr_en),
    .base    (cmd_obase),
    .addr    (res_wr_addr),
    .last    (r_last)
  );

`ifdef RSA_SEQ_TIMEOUT_EN
  localparam int unsigned TO_W = clog2(TO_CYC + 1);

  logic [TO_W-1:0] wd;

  // Watchdog: counts cycles spent in DRAIN, cleared elsewhere.
  always_ff @(posedge clk) begin
    if (sys_rst || (state != DRAIN)) wd <= '0;
    else                             wd <= wd + TO_W'(1);
  end

  assign wd_hit = (state == DRAIN) && (wd == TO_W'(TO_CYC - 1));
`else
  assign wd_hit = 1'b0;
`endif

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state   <= IDLE;
      cmd_rdy <= 1'b1;
      x_rd_en <= 1'b0;
      y_rd_en <= 1'b0;
      Xin_val <= 1'b0;
      Yin_val <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      res_all <= 1'b0;
    end else begin
      Xin_val <= x_rd_en;
      Yin_val <= y_rd_en;
      // All results may already be in before LOAD finishes.
      if (res_wr_en && r_last) res_all <= 1'b1;
      case (state)
        IDLE: begin
          if (cmd_val) begin
            state   <= LOAD;
            cmd_rdy <= 1'b0;
            busy    <= 1'b1;
            x_rd_en <= 1'b1;
            y_rd_en <= 1'b1;
            err     <= 1'b0;
            res_all <= 1'b0;
          end
        end
        LOAD: begin
          if (y_rd_en && y_last) y_rd_en <= 1'b0;
          if (x_rd_en && x_last) begin
            x_rd_en <= 1'b0;
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          if ((res_wr_en && r_last) || res_all) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (wd_hit) begin
            state   <= IDLE;
            busy    <= 1'b0;
            cmd_rdy <= 1'b1;
            err     <= 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          done    <= 1'b0;
          cmd_rdy <= 1'b1;
        end
        default: state <= IDLE;
      endcase
      // A result with no job to own it is dropped and flagged.
      if (((state == IDLE) || (state == DONE)) && out_val) err <= 1'b1;
    end
  end

endmodule
